// File: rtl/program_loader.sv
// Assembles MSB-first bytes into words and writes them to instruction memory until HALT_WORD or memory full.
// One write cycle after each 4th accepted byte; o_byte_ready drops during the write and outside a load.
module program_loader #(
  parameter int unsigned          NB_DATA   = 32,
  parameter int unsigned          NB_ADDR   = 8,
  parameter logic [NB_DATA-1:0]   HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [7:0]         i_byte,
  input  logic               i_byte_valid,
  output logic               o_byte_ready,
  output logic               o_we,
  output logic [NB_ADDR-1:0] o_waddr,
  output logic [NB_DATA-1:0] o_wdata,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overflow,
  output logic [NB_ADDR-2:0] o_word_count
);

  localparam int unsigned        NBYTES    = NB_DATA / 8;
  localparam int unsigned        NB_BCNT   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(NBYTES - 1);
  localparam logic [NB_ADDR-1:0] LAST_ADDR = {{(NB_ADDR-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t             state;
  logic [NB_BCNT-1:0] byte_cnt;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      o_byte_ready <= 1'b0;
      o_we         <= 1'b0;
      o_waddr      <= '0;
      o_wdata      <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_overflow   <= 1'b0;
      o_word_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            state        <= RECV;
            byte_cnt     <= '0;
            o_waddr      <= '0;
            o_word_count <= '0;
            o_done       <= 1'b0;
            o_overflow   <= 1'b0;
            o_byte_ready <= 1'b1;
            o_busy       <= 1'b1;
          end
        end
        RECV: begin
          if (i_byte_valid && o_byte_ready) begin
            // Byte k lands in its own lane, so a partial word survives valid gaps untouched
            for (int k = 0; k < NBYTES; k++) begin
              if (byte_cnt == NB_BCNT'(k)) o_wdata[NB_DATA-1-8*k -: 8] <= i_byte;
            end
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt     <= '0;
              state        <= WRITE;
              o_byte_ready <= 1'b0;
              o_we         <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + NB_BCNT'(1);
            end
          end
        end
        WRITE: begin
          o_we         <= 1'b0;
          o_word_count <= o_word_count + (NB_ADDR-1)'(1);
          if (o_wdata == HALT_WORD) begin
            state  <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else if (o_waddr == LAST_ADDR) begin
            state      <= DONE;
            o_busy     <= 1'b0;
            o_done     <= 1'b1;
            o_overflow <= 1'b1;
          end else begin
            state        <= RECV;
            o_waddr      <= o_waddr + NB_ADDR'(4);
            o_byte_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a per-cycle vector table plus overflow and mid-word reset sequences.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, byte_valid;
  logic [7:0]  byte_in;
  logic        byte_ready, we, busy, done, overflow;
  logic [7:0]  waddr;
  logic [31:0] wdata;
  logic [6:0]  word_count;

  always #5 clk = ~clk;

  program_loader #(
    .NB_DATA   (32),
    .NB_ADDR   (8),
    .HALT_WORD (32'hFFFF_FFFF)
  ) dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_byte       (byte_in),
    .i_byte_valid (byte_valid),
    .o_byte_ready (byte_ready),
    .o_we         (we),
    .o_waddr      (waddr),
    .o_wdata      (wdata),
    .o_busy       (busy),
    .o_done       (done),
    .o_overflow   (overflow),
    .o_word_count (word_count)
  );

  typedef struct packed {
    logic        rdy;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [6:0]  cnt;
  } outs_t;

  typedef struct packed {
    logic       rst_n;
    logic       start;
    logic [7:0] b;
    logic       vld;
    outs_t      exp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int we_pulses = 0;

  always @(negedge clk) if (we === 1'b1) we_pulses++;

  function automatic vec_t mk(input logic r, input logic s, input logic [7:0] b, input logic v,
                              input logic rdy, input logic w, input logic [7:0] a, input logic [31:0] d,
                              input logic bz, input logic dn, input logic ov, input logic [6:0] c);
    vec_t x;
    x.rst_n = r; x.start = s; x.b = b; x.vld = v;
    x.exp = '{rdy: rdy, we: w, addr: a, data: d, busy: bz, done: dn, ovf: ov, cnt: c};
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string name, input outs_t e);
    outs_t a;
    a = '{rdy: byte_ready, we: we, addr: waddr, data: wdata, busy: busy, done: done, ovf: overflow, cnt: word_count};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got rdy=%b we=%b addr=%h data=%h busy=%b done=%b ovf=%b cnt=%0d, want rdy=%b we=%b addr=%h data=%h busy=%b done=%b ovf=%b cnt=%0d",
               name, a.rdy, a.we, a.addr, a.data, a.busy, a.done, a.ovf, a.cnt,
               e.rdy, e.we, e.addr, e.data, e.busy, e.done, e.ovf, e.cnt);
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Feeds one word MSB first, then expects the write pulse on the cycle after the 4th byte
  task automatic send_word(input logic [31:0] w, input logic [7:0] exp_addr, input string tag);
    int g;
    for (int k = 0; k < 4; k++) begin
      g = 0;
      while (byte_ready !== 1'b1 && g < 8) begin
        tick();
        g++;
      end
      if (byte_ready !== 1'b1) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s ready_timeout: got %b want 1", tag, byte_ready);
      end
      byte_in    = w[31-8*k -: 8];
      byte_valid = 1'b1;
      tick();
      byte_valid = 1'b0;
    end
    check_val({tag, "_write"}, {23'd0, we, exp_addr == waddr ? exp_addr : waddr, wdata},
              {23'd0, 1'b1, exp_addr, w});
  endtask

  vec_t vt[19];
  int   p;

  initial begin
    rst_n = 1'b0; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;

    // Reset, two-word load with halt, valid toggling, start held while busy, restart from DONE
    vt[0]  = mk(0,0,8'h00,0, 0,0,8'h00,32'h0000_0000, 0,0,0,7'd0);
    vt[1]  = mk(1,0,8'h00,0, 0,0,8'h00,32'h0000_0000, 0,0,0,7'd0);
    vt[2]  = mk(1,1,8'h00,0, 1,0,8'h00,32'h0000_0000, 1,0,0,7'd0);
    vt[3]  = mk(1,1,8'h20,1, 1,0,8'h00,32'h2000_0000, 1,0,0,7'd0);
    vt[4]  = mk(1,1,8'h08,1, 1,0,8'h00,32'h2008_0000, 1,0,0,7'd0);
    vt[5]  = mk(1,1,8'h00,1, 1,0,8'h00,32'h2008_0000, 1,0,0,7'd0);
    vt[6]  = mk(1,1,8'h05,1, 0,1,8'h00,32'h2008_0005, 1,0,0,7'd0);
    vt[7]  = mk(1,1,8'hAA,1, 1,0,8'h04,32'h2008_0005, 1,0,0,7'd1);
    vt[8]  = mk(1,0,8'hFF,0, 1,0,8'h04,32'h2008_0005, 1,0,0,7'd1);
    vt[9]  = mk(1,0,8'hFF,1, 1,0,8'h04,32'hFF08_0005, 1,0,0,7'd1);
    vt[10] = mk(1,0,8'hFF,0, 1,0,8'h04,32'hFF08_0005, 1,0,0,7'd1);
    vt[11] = mk(1,0,8'hFF,1, 1,0,8'h04,32'hFFFF_0005, 1,0,0,7'd1);
    vt[12] = mk(1,0,8'hFF,0, 1,0,8'h04,32'hFFFF_0005, 1,0,0,7'd1);
    vt[13] = mk(1,0,8'hFF,1, 1,0,8'h04,32'hFFFF_FF05, 1,0,0,7'd1);
    vt[14] = mk(1,0,8'hFF,0, 1,0,8'h04,32'hFFFF_FF05, 1,0,0,7'd1);
    vt[15] = mk(1,0,8'hFF,1, 0,1,8'h04,32'hFFFF_FFFF, 1,0,0,7'd1);
    vt[16] = mk(1,0,8'h00,0, 0,0,8'h04,32'hFFFF_FFFF, 0,1,0,7'd2);
    vt[17] = mk(1,0,8'h11,1, 0,0,8'h04,32'hFFFF_FFFF, 0,1,0,7'd2);
    vt[18] = mk(1,1,8'h00,0, 1,0,8'h00,32'hFFFF_FFFF, 1,0,0,7'd0);

    for (int i = 0; i < 19; i++) begin
      rst_n = vt[i].rst_n; start = vt[i].start; byte_in = vt[i].b; byte_valid = vt[i].vld;
      tick();
      check_outs($sformatf("vec%0d", i), vt[i].exp);
    end
    start = 1'b0; byte_valid = 1'b0;
    check_val("table_we_pulses", 64'(we_pulses), 64'd2);

    // Fill all 64 word slots with non-halt data
    for (int i = 0; i < 64; i++)
      send_word(32'h1000_0000 + 32'(i), 8'(4 * i), $sformatf("ovf_w%0d", i));
    tick();
    check_outs("ovf_done", '{rdy: 1'b0, we: 1'b0, addr: 8'hFC, data: 32'h1000_003F,
                             busy: 1'b0, done: 1'b1, ovf: 1'b1, cnt: 7'd64});
    p = we_pulses;
    for (int k = 0; k < 4; k++) begin
      byte_in = 8'h40 + 8'(k); byte_valid = 1'b1;
      tick();
      check_val($sformatf("ovf_65th_rdy%0d", k), {63'd0, byte_ready}, 64'd0);
    end
    byte_valid = 1'b0;
    tick();
    check_val("ovf_no_extra_we", 64'(we_pulses), 64'(p));

    // Reset partway into the third word
    start = 1'b1; tick(); start = 1'b0;
    send_word(32'h0102_0304, 8'h00, "rst_w1");
    send_word(32'h0506_0708, 8'h04, "rst_w2");
    tick();
    byte_in = 8'h09; byte_valid = 1'b1; tick();
    byte_in = 8'h0A; tick();
    byte_valid = 1'b0;
    check_val("rst_partial", {32'd0, wdata}, {32'd0, 32'h090A_0708});
    p = we_pulses;
    rst_n = 1'b0; start = 1'b1; byte_in = 8'h0B; byte_valid = 1'b1;
    tick();
    check_outs("rst_mid", '0);
    rst_n = 1'b1; start = 1'b0; byte_in = 8'h0C;
    tick(); tick();
    check_outs("rst_idle", '0);
    check_val("rst_no_we", 64'(we_pulses), 64'(p));
    byte_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    send_word(32'hFFFF_FFFF, 8'h00, "reload");
    tick();
    check_outs("reload_done", '{rdy: 1'b0, we: 1'b0, addr: 8'h00, data: 32'hFFFF_FFFF,
                                busy: 1'b0, done: 1'b1, ovf: 1'b0, cnt: 7'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
